// File: rtl/mmio_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_display_pkg
// Purpose  : Register map, bit positions and state type for mmio_display_port.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_display_pkg;

    localparam logic [4:0] OFF_DATA   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_CTRL   = 5'h08;
    localparam logic [4:0] OFF_DIRECT = 5'h0C;
    localparam logic [4:0] OFF_OVF    = 5'h10;
    localparam logic [4:0] OFF_CYC    = 5'h14;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 4;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/disp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : disp_fifo
// Purpose  : First-word-fall-through FIFO queueing values for the display.
// Revision : 1.0 - initial release
// ============================================================================
module disp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_rd;
    logic w_wr;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full queue is accepted when the head leaves in the same cycle.
    assign w_rd = pop & ~empty & ~flush;
    assign w_wr = push & (~full | w_rd) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_display_port.sv
`default_nettype none
// ============================================================================
// Module   : mmio_display_port
// Purpose  : Bus-mapped queue that paces CPU-stored values onto the 7-seg R0/R1.
//            Define MMIO_DISP_CYCLE_COUNTER_EN to add the cycle counter at 0x14.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_display_port
    import mmio_display_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    output logic [15:0] R0,
    output logic [15:0] R1
);

    localparam int              CW              = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int              NW              = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   c_hold_reload   = CW'(HOLD_CYCLES - 1);

    state_t         r_state;
    logic [31:0]    r_shown;
    logic [CW-1:0]  r_hold;
    logic           r_enable;
    logic [31:0]    r_ovf;

    logic [4:0]     w_offset;
    logic           w_wr;
    logic           w_push;
    logic           w_clear;
    logic           w_direct;
    logic           w_pop;
    logic [31:0]    w_fifo_dout;
    logic [NW-1:0]  w_count;
    logic [31:0]    w_count32;
    logic           w_full;
    logic           w_empty;
    logic           w_unused_addr;

    assign sel           = (address[31:5] == BASE_ADDR[31:5]);
    assign w_offset      = {address[4:2], 2'b00};
    assign w_unused_addr = ^address[1:0];
    assign w_wr          = we & sel;
    assign w_push        = w_wr & (w_offset == OFF_DATA);
    assign w_clear       = w_wr & (w_offset == OFF_CTRL) & write_data[CTRL_CLEAR];
    assign w_direct      = w_wr & (w_offset == OFF_DIRECT);

    // Pop only when idle or the current hold has run out; clear/direct win.
    assign w_pop = r_enable & ~w_empty & ~w_clear & ~w_direct
                 & ((r_state == IDLE) | (r_hold == '0));

    disp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_clear | w_direct),
        .din   (write_data),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shown  <= '0;
            r_hold   <= '0;
            r_enable <= 1'b1;
            r_ovf    <= '0;
        end else begin
            if (w_wr && (w_offset == OFF_CTRL))
                r_enable <= write_data[CTRL_ENABLE];

            if (w_wr && (w_offset == OFF_OVF))
                r_ovf <= '0;
            else if (w_push && w_full && !w_pop && (r_ovf != 32'hFFFF_FFFF))
                r_ovf <= r_ovf + 32'd1;

            if (w_direct) begin
                r_shown <= write_data;
                r_hold  <= c_hold_reload;
                r_state <= SHOW;
            end else if (w_pop) begin
                r_shown <= w_fifo_dout;
                r_hold  <= c_hold_reload;
                r_state <= SHOW;
            end else if (r_state == SHOW) begin
                if (r_hold != '0)
                    r_hold <= r_hold - 1'b1;
                else
                    r_state <= IDLE;
            end
        end
    end

`ifdef MMIO_DISP_CYCLE_COUNTER_EN
    logic [31:0] r_cyc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cyc <= '0;
        else if (w_wr && (w_offset == OFF_CYC))
            r_cyc <= write_data;
        else
            r_cyc <= r_cyc + 32'd1;
    end
`endif

    assign w_count32 = 32'(w_count);

    always_comb begin
        read_data = '0;
        if (sel) begin
            case (w_offset)
                OFF_DATA:   read_data = r_shown;
                OFF_STATUS: begin
                    read_data[STAT_EMPTY]             = w_empty;
                    read_data[STAT_FULL]              = w_full;
                    read_data[STAT_BUSY]              = (r_state == SHOW);
                    read_data[STAT_COUNT_LSB +: 4]    = w_count32[3:0];
                end
                OFF_CTRL:   read_data[CTRL_ENABLE] = r_enable;
                OFF_OVF:    read_data = r_ovf;
`ifdef MMIO_DISP_CYCLE_COUNTER_EN
                OFF_CYC:    read_data = r_cyc;
`endif
                default:    read_data = '0;
            endcase
        end
    end

    assign R0 = r_shown[15:0];
    assign R1 = r_shown[31:16];

endmodule
`default_nettype wire

// File: tb/tb_mmio_display_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_display_port
// Purpose  : Directed and random bus traffic checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_display_port;

    localparam int          H    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        sel;
    logic [15:0] R0;
    logic [15:0] R1;

    always #5 clk = ~clk;

    mmio_display_port #(
        .BASE_ADDR   (BASE),
        .DEPTH       (D),
        .HOLD_CYCLES (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .sel        (sel),
        .R0         (R0),
        .R1         (R1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: display contents, pending queue and remaining hold time.
    logic [31:0] m_q[$];
    logic [31:0] m_shown;
    bit          m_show;
    int          m_cnt;
    bit          m_en;
    logic [31:0] m_ovf;
    logic [31:0] m_cyc;

    function automatic void model_reset();
        m_q.delete();
        m_shown = '0;
        m_show  = 0;
        m_cnt   = 0;
        m_en    = 1;
        m_ovf   = '0;
        m_cyc   = '0;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] v = '0;
        if (a[31:5] == BASE[31:5]) begin
            case (int'(a[4:2]))
                0: v = m_shown;
                1: v = (32'(m_q.size()) << 4) | (32'(m_show) << 2)
                     | (32'(m_q.size() == D) << 1) | 32'(m_q.size() == 0);
                2: v = 32'(m_en);
                4: v = m_ovf;
`ifdef MMIO_DISP_CYCLE_COUNTER_EN
                5: v = m_cyc;
`endif
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic void model_step(logic w, logic [31:0] a, logic [31:0] d);
        bit hit     = w && (a[31:5] == BASE[31:5]);
        int off     = int'(a[4:2]);
        bit clr     = hit && off == 2 && d[1];
        bit dir     = hit && off == 3;
        bit psh     = hit && off == 0;
        bit can_pop = m_en && m_q.size() != 0 && !clr && !dir && (!m_show || m_cnt == 0);
        if (dir) begin
            m_shown = d;
            m_q.delete();
            m_cnt  = H - 1;
            m_show = 1;
        end else if (can_pop) begin
            m_shown = m_q.pop_front();
            m_cnt   = H - 1;
            m_show  = 1;
        end else if (m_show) begin
            if (m_cnt != 0) m_cnt--;
            else            m_show = 0;
        end
        if (clr) m_q.delete();
        if (psh) begin
            if (m_q.size() < D)               m_q.push_back(d);
            else if (m_ovf != 32'hFFFF_FFFF)  m_ovf++;
        end
        if (hit && off == 2) m_en  = d[0];
        if (hit && off == 4) m_ovf = '0;
        if (hit && off == 5) m_cyc = d;
        else                 m_cyc = m_cyc + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check the combinational read before the edge, outputs after it.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; address = a; write_data = d;
        #1;
        check("sel", 32'(sel), 32'(a[31:5] == BASE[31:5]));
        check("read_data", read_data, model_read(a));
        @(posedge clk);
        model_step(w, a, d);
        #1;
        check("R0", 32'(R0), 32'(m_shown[15:0]));
        check("R1", 32'(R1), 32'(m_shown[31:16]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, BASE + 32'h04, 32'h0);
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; address = '0; write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        bus(1'b0, BASE + 32'h04, 32'h0);
        bus(1'b0, BASE + 32'h08, 32'h0);
        bus(1'b0, BASE + 32'h00, 32'h0);

        // Single value, full hold then idle
        bus(1'b1, BASE + 32'h00, 32'h1234_ABCD);
        idle(7);
        bus(1'b0, BASE + 32'h00, 32'h0);

        // Disabled queue fills, overflow counted, then drains in order
        bus(1'b1, BASE + 32'h08, 32'h0);
        for (int i = 0; i < 5; i++) bus(1'b1, BASE + 32'h00, 32'hA000_0000 + 32'(i));
        bus(1'b0, BASE + 32'h10, 32'h0);
        bus(1'b1, BASE + 32'h08, 32'h1);
        idle(20);
        bus(1'b1, BASE + 32'h10, 32'h5);
        bus(1'b0, BASE + 32'h10, 32'h0);

        // Clear with three queued mid-hold
        for (int i = 0; i < 4; i++) bus(1'b1, BASE + 32'h00, 32'hC000_0000 + 32'(i));
        bus(1'b1, BASE + 32'h08, 32'h3);
        idle(6);

        // Direct write mid-hold with two queued
        for (int i = 0; i < 3; i++) bus(1'b1, BASE + 32'h00, 32'hD000_0000 + 32'(i));
        bus(1'b1, BASE + 32'h0C, 32'hDEAD_BEEF);
        bus(1'b0, BASE + 32'h04, 32'h0);

        // Asynchronous reset mid-hold
        address = BASE + 32'h04;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("R0_async_reset", 32'(R0), 32'h0);
        check("R1_async_reset", 32'(R1), 32'h0);
        check("status_async_reset", read_data, 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Cycle counter wrap (reads 0 when the feature is absent)
        bus(1'b1, BASE + 32'h14, 32'hFFFF_FFFE);
        bus(1'b0, BASE + 32'h00, 32'h0);
        bus(1'b0, BASE + 32'h14, 32'h0);
        bus(1'b0, BASE + 32'h18, 32'h0);
        bus(1'b1, BASE + 32'h1C, 32'h1);
        bus(1'b1, 32'h0000_1000, 32'h5555_5555);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            d = $urandom;
            w = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (a[31:5] == BASE[31:5] && a[4:2] == 3'd2 && $urandom_range(0, 3) != 0) begin
                d[0] = 1'b1;
                if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
            end
            if (a[31:5] == BASE[31:5] && a[4:2] == 3'd3 && $urandom_range(0, 3) != 0) w = 1'b0;
            bus(w, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_display_port.md
Name: mmio_display_port

Overview:
Memory-mapped responder on the processor data bus (we/address/write_data/read_data), decoded alongside the data memory. CPU stores push 32-bit values into a small queue. The block rotates queued values onto the R0/R1 inputs of the 7-segment display controller, holding each for a programmable time. It turns program results into a visible, paced sequence instead of needing a register tap.

Parameters:
BASE_ADDR, 32'hFFFF_0000, byte address of register 0; block responds to BASE_ADDR..BASE_ADDR+0x1F.
DEPTH, 4, queue entries; power of two, at least 2.
HOLD_CYCLES, 50_000_000, clk cycles each value stays displayed; at least 1.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
we  in  1  bus write strobe; valid only when sel=1.
address  in  32  bus byte address; bits [1:0] ignored.
write_data  in  32  bus store data.
read_data  out  32  combinational read data; 0 when sel=0.
sel  out  1  combinational; 1 when address[31:5]==BASE_ADDR[31:5].
R0  out  16  shown value [15:0] to the display controller.
R1  out  16  shown value [31:16] to the display controller.

Behaviour:
- Register map, word offsets:
  - 0x00 DATA: write pushes to the queue; read returns the shown value.
  - 0x04 STATUS, read-only: [0]=empty, [1]=full, [2]=busy (state SHOW), [7:4]=count.
  - 0x08 CTRL: [0]=enable, read/write. [1]=clear, write-1 self-clearing, reads 0.
  - 0x0C DIRECT: write-only, reads 0.
  - 0x10 OVF: read; any write clears it to 0.
  - Other offsets read 0; writes to them are ignored.
- Reset (reset=0, async): shown=0, queue empty, OVF=0, enable=1, state IDLE, hold counter=0. R0/R1 therefore read 0.
- State machine:
  - IDLE: if enable and queue non-empty, pop into shown, load counter=HOLD_CYCLES-1, go to SHOW.
  - SHOW: if counter!=0, decrement. If counter==0 and queue non-empty and enable, pop into shown and reload the counter. If counter==0 otherwise, go to IDLE.
  - Shown value persists in IDLE.
- Latency: DATA store at edge N (queue empty, IDLE, enable=1) -> entry visible at edge N. R0/R1 change at edge N+1.
- Full queue: push with no pop in the same cycle is dropped and OVF increments, saturating at 32'hFFFF_FFFF. Push with a pop in the same cycle is accepted.
- enable=0: no pops; counter keeps running; state drops to IDLE at counter 0.
- Clear: flushes the queue. Shown value and state are untouched. A DATA push in the same cycle is impossible, since it is a single bus write. A pop in the same cycle is suppressed.
- DIRECT write: shown<=write_data, queue flushed, counter reloaded to HOLD_CYCLES-1, state SHOW. DIRECT has priority over a same-cycle pop.
- Reset asserted mid-hold: immediate return to reset values; no partial pop.
- Width rules:
  - count is log2(DEPTH)+1 bits, zero-extended into [7:4].
  - Counter width is $clog2(HOLD_CYCLES).

Optional Feature:
MMIO_DISP_CYCLE_COUNTER_EN
- Defined: offset 0x14 is a free-running 32-bit cycle counter. Reset 0, increments every cycle, wraps at 2^32. Writes load write_data.
- Not defined: 0x14 reads 0, writes ignored, no counter flops.

Decomposition:
- Package mmio_display_pkg holds:
  - register offset constants (OFF_DATA, OFF_STATUS, OFF_CTRL, OFF_DIRECT, OFF_OVF, OFF_CYC);
  - STATUS/CTRL bit-position constants;
  - state enum {IDLE, SHOW}.
- One sub-module, disp_fifo: synchronous FIFO with parameter DEPTH and 32-bit width.
  - Ports: push, pop, flush, din, dout, count, full, empty. Same clk/reset.
  - Read is first-word-fall-through.

Test Plan:
1. Reset, then read STATUS -> 0x0000_0001. R0=R1=0. CTRL reads 0x1.
2. HOLD_CYCLES=4; store DATA 0x1234_ABCD at edge 10 -> R1=0x1234, R0=0xABCD from edge 11. STATUS busy=1. IDLE after 4 cycles; value stays shown.
3. HOLD_CYCLES=4, enable=0; store 5 values -> first 4 queued, STATUS=0x42. Fifth dropped, OVF=1. Set enable=1 -> values appear in order, every 4 cycles.
4. Queue holding 3 entries mid-SHOW; write CTRL clear -> count=0. Shown value unchanged. IDLE after the counter expires.
5. Mid-SHOW with 2 queued, write DIRECT 0xDEAD_BEEF -> next cycle R1=0xDEAD, R0=0xBEEF, queue empty. Counter restarts at 3. Separately, assert reset mid-hold -> all outputs 0 asynchronously.
6. With MMIO_DISP_CYCLE_COUNTER_EN: write 0x14 with 0xFFFF_FFFE, read 2 cycles later -> 0x0000_0000 (wrap). Without the macro, read of 0x14 -> 0.
